uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Sequencer and arbiter in front of the UART transmit core. It collects bytes from NUM_REQ requesters through a round-robin arbiter and buffers them in a FIFO. It issues each byte to the core with a one-cycle enable pulse, tracks the core's busy handshake, and applies bit-period (baud) reconfiguration only between frames, so a write never lands mid-frame.

Parameters:
NUM_REQ, 2, number of byte requesters (index 0 = CPU MMIO, 1 = debug), range 1..4
FIFO_DEPTH, 8, TX byte FIFO entries, power of two, at least 2
CLK_FREQ, 50000000, system clock in Hz
BAUD_RATE, 115200, reset baud rate
ACK_TIMEOUT, 4, cycles to wait for the core's busy to rise after an enable pulse

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous assertion, active-low
req_valid_i  in  NUM_REQ  per-requester byte valid
req_data_i  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready_o  out  NUM_REQ  one-hot (or zero) grant; a byte transfers when valid and ready are both high
cfg_wr_i  in  1  bit-period write request, single-cycle strobe
cfg_bit_period_i  in  16  new bit period (clocks per bit minus 1)
cfg_pending_o  out  1  a bit-period write is queued but not yet applied
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_full_o  out  1  FIFO full
fifo_empty_o  out  1  FIFO empty
idle_o  out  1  FIFO empty, no config pending, sequencer in S_IDLE, tx_busy_i low
ack_err_o  out  1  sticky; set by an ack timeout, cleared only by reset
tx_en_o  out  1  enable pulse to the core
tx_data_o  out  8  byte to the core
tx_busy_i  in  1  core busy
wr_bit_period_o  out  1  bit-period write strobe to the core
bit_period_o  out  16  bit period to the core

Behaviour:
- Reset (asynchronous): FIFO empty, round-robin pointer at 0, sequencer in S_IDLE, cfg_pending_o=0, ack_err_o=0, tx_en_o=0, tx_data_o=0, wr_bit_period_o=0, bit_period_o=DEFAULT_BIT_PERIOD (CLK_FREQ/BAUD_RATE-1, truncated to 16 bits; 433 at the defaults). A reset mid-frame discards all buffered bytes and any pending config.
- Arbiter:
  - Combinational. While the FIFO is not full, grant the first valid requester at or after the pointer, scanning in increasing index order with wrap.
  - After a transfer, the pointer moves to granted+1 mod NUM_REQ.
  - When the FIFO is full, req_ready_o is all-zero, even if a pop happens in the same cycle.
  - At most one push per cycle.
- FIFO:
  - Synchronous push and pop; push and pop in the same cycle leave the level unchanged.
  - Pop happens only when the FIFO is non-empty. Head data is combinational from the read pointer.
- Config:
  - cfg_wr_i latches cfg_bit_period_i into a shadow register and sets cfg_pending_o.
  - A second write while a config is pending overwrites the shadow value (last write wins).
  - A cfg_wr_i in the same cycle as S_CFG apply takes effect: the new value stays pending for a second apply.
- Sequencer states (all outputs registered):
  - S_IDLE: if tx_busy_i=0 and cfg_pending, go to S_CFG (config has priority over data). Else if tx_busy_i=0 and the FIFO is non-empty: tx_data_o<=head, tx_en_o<=1, pop, go to S_ISSUE.
  - S_CFG: bit_period_o<=shadow, wr_bit_period_o<=1 for exactly one cycle, clear pending, go to S_IDLE.
  - S_ISSUE: tx_en_o<=0, clear the timeout counter, go to S_WAIT_ACK.
  - S_WAIT_ACK: if tx_busy_i=1, go to S_WAIT_DONE. Else the counter increments; when the counter reaches ACK_TIMEOUT, set ack_err_o and go to S_IDLE (the byte is dropped).
  - S_WAIT_DONE: when tx_busy_i=0, go to S_IDLE.
- tx_data_o holds its value until the next issue.
- Latency: a byte accepted at edge N reaches the FIFO at N+1. The sequencer is in S_IDLE and pops at N+1, so tx_en_o is high during cycle N+1..N+2, and the core raises busy by N+3.
- Minimum gap: one S_IDLE cycle between the core dropping busy and the next enable.

Decomposition:
- Shared package uart_pkg:
  - sequencer state enum uart_sched_state_t (S_IDLE, S_CFG, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE)
  - function default_bit_period(CLK_FREQ, BAUD_RATE)
  - 16-bit width constant BIT_PERIOD_W
- Sub-module uart_byte_fifo (parameter DEPTH, width 8), holding the pointer and level logic. The arbiter and sequencer stay in the top module.

Test Plan:
1. Reset, then req0 sends 0x55 with a core model that raises busy 1 cycle after enable and holds it 10 cycles -> exactly one tx_en_o pulse with tx_data_o=0x55, idle_o=1 after busy falls. bit_period_o=433 throughout.
2. req0 and req1 both hold valid continuously, bytes A0..A3 and B0..B3 -> accept order A0,B0,A1,B1,... and tx_data_o issues in the same order.
3. Fill the FIFO with 8 bytes while the core is stuck busy -> fifo_full_o=1, req_ready_o=0, level=8. Release busy -> exactly one pop per frame, and ready returns the cycle after level drops to 7.
4. cfg_wr_i=1 with value 0x1B during a frame, then 0x0D before the frame ends -> exactly one wr_bit_period_o pulse, after busy falls and before the next tx_en_o, with bit_period_o=0x000D.
5. Core model never raises busy -> ack_err_o set 4 cycles after S_WAIT_ACK entry, sequencer returns to S_IDLE, and the next byte issues.
6. Assert rst_n low mid-frame with 3 bytes queued -> all outputs return to reset values asynchronously and fifo_empty_o=1. No tx_en_o for 2 cycles after rst_n rises.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared sequencer state, bit-period width and default bit-period helper
package uart_pkg;
  localparam int BIT_PERIOD_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_CFG, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} uart_sched_state_t;
  function automatic logic [BIT_PERIOD_W-1:0] default_bit_period(input int unsigned clk_freq, input int unsigned baud_rate);
    int unsigned p;
    p = clk_freq / baud_rate - 1;
    return p[BIT_PERIOD_W-1:0];
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// uart_byte_fifo: power-of-two byte FIFO with occupancy level and combinational head
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  always_comb begin
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin byte arbiter, TX FIFO and frame sequencer for the UART core
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [8*NUM_REQ-1:0]          req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          cfg_wr_i,
  input  logic [BIT_PERIOD_W-1:0]       cfg_bit_period_i,
  output logic                          cfg_pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o,
  output logic                          idle_o,
  output logic                          ack_err_o,
  output logic                          tx_en_o,
  output logic [7:0]                    tx_data_o,
  input  logic                          tx_busy_i,
  output logic                          wr_bit_period_o,
  output logic [BIT_PERIOD_W-1:0]       bit_period_o
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BIT_PERIOD_W-1:0] DEFAULT_BP = default_bit_period(CLK_FREQ, BAUD_RATE);
  uart_sched_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_idx, idx;
  logic [NUM_REQ-1:0] gnt;
  logic found, push, pop, cfg_apply;
  logic [7:0] push_data, head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, err_q, err_d, tx_en_q, tx_en_d, wr_bp_q, wr_bp_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [BIT_PERIOD_W-1:0] shadow_q, shadow_d, bp_q, bp_d;
  // First valid requester at or after the pointer; nothing is granted while full
  always_comb begin
    gnt       = '0;
    gnt_idx   = ptr_q;
    found     = 1'b0;
    idx       = '0;
    push_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && !fifo_full_o && req_valid_i[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        push_data = req_data_i[{idx, 3'b000} +: 8];
      end
    end
    push  = found;
    ptr_d = push ? PW'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
  end
  assign req_ready_o = gnt;
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (fifo_level_o),
    .full_o  (fifo_full_o),
    .empty_o (fifo_empty_o)
  );
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    wr_bp_d   = 1'b0;
    bp_d      = bp_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pop       = 1'b0;
    cfg_apply = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy_i && pend_q) state_d = S_CFG;
        else if (!tx_busy_i && !fifo_empty_o) begin
          tx_data_d = head;
          tx_en_d   = 1'b1;
          pop       = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_CFG: begin
        bp_d      = shadow_q;
        wr_bp_d   = 1'b1;
        cfg_apply = 1'b1;
        state_d   = S_IDLE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy_i) state_d = S_WAIT_DONE;
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: state_d = tx_busy_i ? S_WAIT_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A write landing on the apply cycle stays pending for another apply
    pend_d   = cfg_wr_i | (pend_q & ~cfg_apply);
    shadow_d = cfg_wr_i ? cfg_bit_period_i : shadow_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      wr_bp_q   <= 1'b0;
      bp_q      <= DEFAULT_BP;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      wr_bp_q   <= wr_bp_d;
      bp_q      <= bp_d;
      shadow_q  <= shadow_d;
    end
  end
  assign cfg_pending_o   = pend_q;
  assign ack_err_o       = err_q;
  assign tx_en_o         = tx_en_q;
  assign tx_data_o       = tx_data_q;
  assign wr_bit_period_o = wr_bp_q;
  assign bit_period_o    = bp_q;
  assign idle_o          = fifo_empty_o && !pend_q && state_q == S_IDLE && !tx_busy_i;
endmodule
